// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the AXI crossbar.
// Contents: AXI field widths, burst-type encodings, and the read-address
// arbiter state enum.
package axi_xbar_pkg;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ar_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Scans req starting at ptr, wrapping
// modulo N, and returns the first set bit. Shared by the AR and AW arbiters.
// Ports:
//   req  - request vector, one bit per master
//   ptr  - index that currently has highest priority
//   gnt  - one-hot pick, all zero when req is zero
//   idx  - binary index of the pick, zero when req is zero
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_ar_arbiter.sv
// Per-slave read-address arbiter. Qualifies each master's ARVALID with its
// decoder hit, picks a winner, forwards the winner's AR fields with the
// master index prepended to ARID, and holds the grant until the RLAST beat
// so the R return mux can steer on R_GRANT. One outstanding read per slave.
//
// Build option: define AR_ARB_FIXED_PRIO_EN for fixed priority (lowest
// master index wins); default is round-robin.
//
// Ports:
//   ACLK, ARESET         - clock, async active-high reset
//   M_HIT, M_ARVALID     - per-master decoder hit and ARVALID
//   M_ARREADY            - per-master ARREADY (only the granted bit moves)
//   M_AR{ID,ADDR,LEN,SIZE,BURST} - flattened per-master AR fields
//   S_AR*                - slave AR channel, S_ARID = {index, ARID}
//   S_RVALID/RREADY/RLAST - slave R handshake, observed for burst end
//   R_GRANT              - one-hot owner of the in-flight read, 0 when idle
//
// state | meaning
// IDLE  | no read outstanding, arbitrating among qualified requests
// ADDR  | presenting the winner's address to the slave
// DATA  | address accepted, waiting for the RLAST handshake
module axi_ar_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int NUM_MASTER = 2,
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_MASTER-1:0]         M_HIT,
  input  logic [NUM_MASTER-1:0]         M_ARVALID,
  output logic [NUM_MASTER-1:0]         M_ARREADY,
  input  logic [NUM_MASTER*ID_W-1:0]    M_ARID,
  input  logic [NUM_MASTER*ADDR_W-1:0]  M_ARADDR,
  input  logic [NUM_MASTER*LEN_W-1:0]   M_ARLEN,
  input  logic [NUM_MASTER*SIZE_W-1:0]  M_ARSIZE,
  input  logic [NUM_MASTER*BURST_W-1:0] M_ARBURST,
  output logic                          S_ARVALID,
  input  logic                          S_ARREADY,
  output logic [IDX_W+ID_W-1:0]         S_ARID,
  output logic [ADDR_W-1:0]             S_ARADDR,
  output logic [LEN_W-1:0]              S_ARLEN,
  output logic [SIZE_W-1:0]             S_ARSIZE,
  output logic [BURST_W-1:0]            S_ARBURST,
  input  logic                          S_RVALID,
  input  logic                          S_RREADY,
  input  logic                          S_RLAST,
  output logic [NUM_MASTER-1:0]         R_GRANT
);

  ar_state_t               state;
  logic [NUM_MASTER-1:0]   req;
  logic [NUM_MASTER-1:0]   pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_MASTER-1:0]   grant;
  logic [IDX_W-1:0]        gidx;
  logic [IDX_W-1:0]        rr_ptr;
  logic                    in_addr;

  assign req = M_ARVALID & M_HIT;

`ifdef AR_ARB_FIXED_PRIO_EN
  // Scanning from 0 every time gives lowest-index-wins priority.
  assign rr_ptr = '0;
`endif

  rr_arbiter #(
    .N     (NUM_MASTER),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
`ifndef AR_ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick_gnt;
            gidx  <= pick_idx;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (S_ARREADY) begin
`ifndef AR_ARB_FIXED_PRIO_EN
            // The winner drops to lowest priority for the next round.
            rr_ptr <= (gidx == IDX_W'(NUM_MASTER - 1)) ? '0 : gidx + 1'b1;
`endif
            state  <= DATA;
          end
        end
        DATA: begin
          if (S_RVALID && S_RREADY && S_RLAST) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_addr   = (state == ADDR);
  assign S_ARVALID = in_addr;
  assign M_ARREADY = (in_addr && S_ARREADY) ? grant : '0;
  // grant is cleared whenever the FSM is idle, so it doubles as R_GRANT.
  assign R_GRANT   = grant;

  // Fields are zeroed outside ADDR so the slave never sees stale values.
  assign S_ARID    = in_addr ? {gidx, M_ARID[gidx*ID_W +: ID_W]} : '0;
  assign S_ARADDR  = in_addr ? M_ARADDR[gidx*ADDR_W +: ADDR_W] : '0;
  assign S_ARLEN   = in_addr ? M_ARLEN[gidx*LEN_W +: LEN_W] : '0;
  assign S_ARSIZE  = in_addr ? M_ARSIZE[gidx*SIZE_W +: SIZE_W] : '0;
  assign S_ARBURST = in_addr ? M_ARBURST[gidx*BURST_W +: BURST_W] : '0;

  // A granted master dropping ARVALID before the handshake breaks AXI;
  // the arbiter keeps presenting the address regardless.
  ar_valid_held: assert property (@(posedge ACLK) disable iff (ARESET)
    in_addr |-> M_ARVALID[gidx]);

endmodule

// File: tb/tb_axi_ar_arbiter.sv
module tb_axi_ar_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  M_HIT;
  logic [1:0]  M_ARVALID;
  logic [1:0]  M_ARREADY;
  logic [7:0]  M_ARID;
  logic [63:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [5:0]  M_ARSIZE;
  logic [3:0]  M_ARBURST;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [4:0]  S_ARID;
  logic [31:0] S_ARADDR;
  logic [3:0]  S_ARLEN;
  logic [2:0]  S_ARSIZE;
  logic [1:0]  S_ARBURST;
  logic        S_RVALID;
  logic        S_RREADY;
  logic        S_RLAST;
  logic [1:0]  R_GRANT;

  int checks = 0;
  int errors = 0;

  axi_ar_arbiter #(
    .NUM_MASTER (2),
    .ID_W       (4),
    .ADDR_W     (32)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .M_HIT     (M_HIT),
    .M_ARVALID (M_ARVALID),
    .M_ARREADY (M_ARREADY),
    .M_ARID    (M_ARID),
    .M_ARADDR  (M_ARADDR),
    .M_ARLEN   (M_ARLEN),
    .M_ARSIZE  (M_ARSIZE),
    .M_ARBURST (M_ARBURST),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_ARID    (S_ARID),
    .S_ARADDR  (S_ARADDR),
    .S_ARLEN   (S_ARLEN),
    .S_ARSIZE  (S_ARSIZE),
    .S_ARBURST (S_ARBURST),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY),
    .S_RLAST   (S_RLAST),
    .R_GRANT   (R_GRANT)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    M_HIT     = '0;
    M_ARVALID = '0;
    M_ARID    = '0;
    M_ARADDR  = '0;
    M_ARLEN   = '0;
    M_ARSIZE  = '0;
    M_ARBURST = '0;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    S_RREADY  = 1'b0;
    S_RLAST   = 1'b0;
  endtask

  task automatic pulse_reset();
    ARESET = 1'b1;
    step();
    step();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESET = 1'b1;
    step();
    checks++;
    if (S_ARVALID !== 1'b0 || M_ARREADY !== 2'b00 || R_GRANT !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: arvalid=%b arready=%b rgrant=%b expected 0/00/00",
               S_ARVALID, M_ARREADY, R_GRANT);
    end
    checks++;
    if ({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST} !== '0) begin
      errors++;
      $display("FAIL reset_fields: id=%h addr=%h len=%h size=%h burst=%h expected all 0",
               S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST);
    end
    step();
    ARESET = 1'b0;
  endtask

  task automatic test_single();
    M_HIT          = 2'b01;
    M_ARVALID      = 2'b01;
    M_ARID[3:0]    = 4'h3;
    M_ARADDR[31:0] = 32'h0001_0040;
    M_ARLEN[3:0]   = 4'd3;
    M_ARSIZE[2:0]  = 3'd2;
    M_ARBURST[1:0] = 2'b01;
    step();
    checks++;
    if (S_ARVALID !== 1'b1 || S_ARID !== 5'h03 || S_ARADDR !== 32'h0001_0040
        || S_ARLEN !== 4'd3 || S_ARSIZE !== 3'd2 || S_ARBURST !== 2'b01) begin
      errors++;
      $display("FAIL single_addr: arvalid=%b id=%h addr=%h len=%h size=%h burst=%h expected 1/03/00010040/3/2/1",
               S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST);
    end
    checks++;
    if (M_ARREADY !== 2'b00 || R_GRANT !== 2'b01) begin
      errors++;
      $display("FAIL single_wait: arready=%b rgrant=%b expected 00/01", M_ARREADY, R_GRANT);
    end
    S_ARREADY = 1'b1;
    #1;
    checks++;
    if (M_ARREADY !== 2'b01) begin
      errors++;
      $display("FAIL single_arready: got %b expected 01", M_ARREADY);
    end
    step();
    S_ARREADY = 1'b0;
    M_ARVALID = 2'b00;
    checks++;
    if (S_ARVALID !== 1'b0 || M_ARREADY !== 2'b00 || R_GRANT !== 2'b01) begin
      errors++;
      $display("FAIL single_data: arvalid=%b arready=%b rgrant=%b expected 0/00/01",
               S_ARVALID, M_ARREADY, R_GRANT);
    end
    for (int b = 1; b <= 4; b++) begin
      S_RVALID = 1'b1;
      S_RREADY = 1'b1;
      S_RLAST  = (b == 4);
      checks++;
      if (R_GRANT !== 2'b01) begin
        errors++;
        $display("FAIL single_beat%0d_grant: got %b expected 01", b, R_GRANT);
      end
      step();
    end
    S_RVALID = 1'b0;
    S_RREADY = 1'b0;
    S_RLAST  = 1'b0;
    checks++;
    if (R_GRANT !== 2'b00 || S_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rgrant=%b arvalid=%b expected 00/0", R_GRANT, S_ARVALID);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt [3];
    logic [4:0] exp_id  [3];
    exp_gnt[0] = 2'b01; exp_id[0] = 5'h01;
    exp_gnt[1] = 2'b10; exp_id[1] = 5'h12;
    exp_gnt[2] = 2'b01; exp_id[2] = 5'h01;
    pulse_reset();
    M_HIT     = 2'b11;
    M_ARVALID = 2'b11;
    M_ARID    = 8'h21;
    M_ARADDR  = {32'h0000_0200, 32'h0000_0100};
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (S_ARVALID !== 1'b1 || S_ARID !== exp_id[n] || R_GRANT !== exp_gnt[n]) begin
        errors++;
        $display("FAIL b2b_grant%0d: arvalid=%b id=%h rgrant=%b expected 1/%h/%b",
                 n, S_ARVALID, S_ARID, R_GRANT, exp_id[n], exp_gnt[n]);
      end
      S_ARREADY = 1'b1;
      #1;
      checks++;
      if (M_ARREADY !== exp_gnt[n]) begin
        errors++;
        $display("FAIL b2b_arready%0d: got %b expected %b", n, M_ARREADY, exp_gnt[n]);
      end
      step();
      S_ARREADY = 1'b0;
      S_RVALID  = 1'b1;
      S_RREADY  = 1'b1;
      S_RLAST   = 1'b1;
      step();
      S_RVALID = 1'b0;
      S_RREADY = 1'b0;
      S_RLAST  = 1'b0;
      if (n == 2) M_ARVALID = 2'b00;
      checks++;
      if (S_ARVALID !== 1'b0 || R_GRANT !== 2'b00) begin
        errors++;
        $display("FAIL b2b_bubble%0d: arvalid=%b rgrant=%b expected 0/00", n, S_ARVALID, R_GRANT);
      end
    end
    clear_inputs();
  endtask

  task automatic test_hit_mask();
    M_HIT     = 2'b00;
    M_ARVALID = 2'b10;
    S_ARREADY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (S_ARVALID !== 1'b0 || M_ARREADY !== 2'b00 || R_GRANT !== 2'b00) begin
        errors++;
        $display("FAIL hit_mask%0d: arvalid=%b arready=%b rgrant=%b expected 0/00/00",
                 c, S_ARVALID, M_ARREADY, R_GRANT);
      end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    M_HIT           = 2'b10;
    M_ARVALID       = 2'b10;
    M_ARID[7:4]     = 4'hA;
    M_ARADDR[63:32] = 32'hDEAD_BEE0;
    M_ARLEN[7:4]    = 4'd7;
    M_ARSIZE[5:3]   = 3'd2;
    M_ARBURST[3:2]  = 2'b10;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (S_ARVALID !== 1'b1 || S_ARID !== 5'h1A || S_ARADDR !== 32'hDEAD_BEE0
          || S_ARLEN !== 4'd7 || S_ARSIZE !== 3'd2 || S_ARBURST !== 2'b10
          || M_ARREADY !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d: arvalid=%b id=%h addr=%h len=%h size=%h burst=%h arready=%b expected 1/1a/deadbee0/7/2/2/00",
                 c, S_ARVALID, S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, M_ARREADY);
      end
      step();
    end
    S_ARREADY = 1'b1;
    #1;
    checks++;
    if (M_ARREADY !== 2'b10) begin
      errors++;
      $display("FAIL bp_arready: got %b expected 10", M_ARREADY);
    end
    step();
    S_ARREADY = 1'b0;
    M_ARVALID = 2'b00;
    checks++;
    if (S_ARVALID !== 1'b0 || R_GRANT !== 2'b10) begin
      errors++;
      $display("FAIL bp_data: arvalid=%b rgrant=%b expected 0/10", S_ARVALID, R_GRANT);
    end
  endtask

  task automatic test_rready_stall();
    S_RVALID = 1'b1;
    S_RLAST  = 1'b1;
    S_RREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (R_GRANT !== 2'b10) begin
        errors++;
        $display("FAIL stall%0d_grant: got %b expected 10", c, R_GRANT);
      end
    end
    S_RREADY = 1'b1;
    step();
    checks++;
    if (R_GRANT !== 2'b00) begin
      errors++;
      $display("FAIL stall_release: got %b expected 00", R_GRANT);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_data();
    // M0 wins so the round-robin pointer moves to M1 before the reset.
    M_HIT     = 2'b01;
    M_ARVALID = 2'b01;
    M_ARID    = 8'h65;
    step();
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    M_ARVALID = 2'b00;
    checks++;
    if (R_GRANT !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre_grant: got %b expected 01", R_GRANT);
    end
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if (S_ARVALID !== 1'b0 || M_ARREADY !== 2'b00 || R_GRANT !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: arvalid=%b arready=%b rgrant=%b expected 0/00/00",
               S_ARVALID, M_ARREADY, R_GRANT);
    end
    step();
    ARESET    = 1'b0;
    M_HIT     = 2'b11;
    M_ARVALID = 2'b11;
    step();
    checks++;
    if (R_GRANT !== 2'b01 || S_ARID !== 5'h05) begin
      errors++;
      $display("FAIL rst_ptr: rgrant=%b id=%h expected 01/05", R_GRANT, S_ARID);
    end
    ARESET = 1'b1;
    step();
    clear_inputs();
    ARESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hit_mask();
    test_backpressure();
    test_rready_stall();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Per-slave read-address arbiter for the crossbar, directly downstream of the address decoder.
- Each instance takes one decoder hit bit per master, qualifies it with that master's ARVALID, and picks one winner round-robin.
- It forwards the winner's AR fields to its slave port with the master index prepended to ARID.
- It holds the grant until the slave returns RLAST, so the R-channel return mux can use the registered grant.
- One outstanding read per slave.

Parameters:
- NUM_MASTER, 2, number of master ports (≥1).
- ID_W, 4, master-side ARID width.
- ADDR_W, 32, address width.
- IDX_W, $clog2(NUM_MASTER) (min 1), master index width, prepended to ARID.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- M_HIT  in  NUM_MASTER  decoder hit bit for this slave, one per master.
- M_ARVALID  in  NUM_MASTER  per-master ARVALID.
- M_ARREADY  out  NUM_MASTER  per-master ARREADY.
- M_ARID  in  NUM_MASTER*ID_W  flattened ARID.
- M_ARADDR  in  NUM_MASTER*ADDR_W  flattened ARADDR.
- M_ARLEN  in  NUM_MASTER*4  flattened ARLEN.
- M_ARSIZE  in  NUM_MASTER*3  flattened ARSIZE.
- M_ARBURST  in  NUM_MASTER*2  flattened ARBURST.
- S_ARVALID  out  1  slave ARVALID.
- S_ARREADY  in  1  slave ARREADY.
- S_ARID  out  IDX_W+ID_W  {granted index, ARID}.
- S_ARADDR  out  ADDR_W  forwarded address.
- S_ARLEN  out  4  forwarded burst length.
- S_ARSIZE  out  3  forwarded burst size.
- S_ARBURST  out  2  forwarded burst type.
- S_RVALID  in  1  slave RVALID (observed only).
- S_RREADY  in  1  RREADY as driven back to the slave by the R mux (observed only).
- S_RLAST  in  1  slave RLAST.
- R_GRANT  out  NUM_MASTER  one-hot owner of the in-flight read; 0 when idle.

Behaviour:
- Request qualification: req[i] = M_ARVALID[i] & M_HIT[i].
- Reset: state=IDLE, rr_ptr=0, grant=0.
- Outputs at reset: S_ARVALID=0, M_ARREADY=0, R_GRANT=0, all S_AR* fields=0.
- FSM IDLE:
  - S_ARVALID=0, R_GRANT=0.
  - If req≠0, select the first set bit scanning from rr_ptr upward with wrap.
  - Register the selection as one-hot grant; go to ADDR.
  - Latency: S_ARVALID rises exactly 1 cycle after req is sampled.
- FSM ADDR:
  - S_ARVALID=1.
  - S_AR* muxed combinationally from the granted master's inputs; S_ARID={idx,ID}.
  - M_ARREADY[g]=S_ARREADY; all other M_ARREADY bits=0. R_GRANT=grant.
  - On S_ARREADY=1: rr_ptr←(g+1) mod NUM_MASTER, go to DATA.
  - S_ARVALID holds until the handshake, even if the master deasserts ARVALID (protocol violation; flagged by assertion, no abort).
- FSM DATA:
  - S_ARVALID=0, M_ARREADY=0, R_GRANT=grant.
  - On S_RVALID & S_RREADY & S_RLAST: go to IDLE; grant cleared.
- Back-to-back: the RLAST beat and a pending request in the same cycle → IDLE next cycle, arbitration there. Fixed 1-cycle bubble between bursts.
- Fairness: a master that just won has lowest priority next round. With N requesters, each is served within N bursts.
- NUM_MASTER=1: IDX_W=1 and the index bit is always 0; rr_ptr stays 0.
- Non-winner requests are ignored in ADDR/DATA, with no ARREADY; masters keep ARVALID high per AXI.
- Reset asserted mid-burst: immediate return to reset values. The outstanding slave burst is abandoned; the system resets slaves together.

Optional Feature:
- Macro: AR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest master index wins. rr_ptr is not implemented and is treated as 0.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package axi_xbar_pkg holds:
  - burst type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10);
  - the ar_state_t enum {IDLE, ADDR, DATA};
  - the AXI field width constants (LEN_W=4, SIZE_W=3, BURST_W=2).
- One sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: req and rr_ptr. Outputs: one-hot grant and index.
  - Reused by the future AW arbiter.

Test Plan:
- Single request: M0 hit+ARVALID with ARADDR=0x0001_0040, ARID=3, ARLEN=3 at cycle 0.
  - S_ARVALID=1 at cycle 1 with S_ARID={0,3} and S_ARADDR=0x0001_0040.
  - S_ARREADY at cycle 2 → M_ARREADY[0] pulses in cycle 2.
  - R_GRANT=01 until the 4th beat with RLAST.
- Contention: M0 and M1 request continuously.
  - Grants alternate M0, M1, M0.
  - Each S_ARVALID begins 1 cycle after the prior RLAST handshake.
- Hit masking: M1 ARVALID=1 with hit=0 → S_ARVALID never asserts and M_ARREADY[1] stays 0.
- Slave backpressure: S_ARREADY held 0 for 5 cycles.
  - S_ARVALID and fields stay stable; no M_ARREADY.
  - Handshake in cycle 6 moves the FSM to DATA.
- RVALID=1, RLAST=1 but RREADY=0 for 3 cycles → remains in DATA; releases on the cycle RREADY=1.
- Reset mid-DATA: ARESET pulsed → S_ARVALID, M_ARREADY and R_GRANT=0 immediately; next grant goes to M0 (rr_ptr=0).
